uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that consumes the single-wire UART line produced by the team's transmitter, or by a host adapter, and delivers parallel bytes to the sequencer command decoder through a valid/ready handshake. The line format is 8N1 by default: start bit low, DATA_WIDTH data bits LSB first, one stop bit high. Sampling uses a fixed clock-count bit timer with mid-bit sampling. The block reports framing errors and overruns as one-cycle pulses.

## Interface
- DATA_WIDTH, 8, bits per frame
- BAUD_RATE, 115200, line rate
- CLK_FREQ, 12_000_000, clk frequency in Hz
- Derived: PULSE_WIDTH = CLK_FREQ/BAUD_RATE (104 at defaults); HALF_PULSE_WIDTH = PULSE_WIDTH/2 (52)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- sig  in  1  asynchronous serial line, idle high
- data  out  DATA_WIDTH  received byte, stable while valid=1
- valid  out  1  byte available
- ready  in  1  consumer accepts; transfer occurs on a cycle where valid && ready
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: frame completed while valid still high

## Operation
- sig passes through a 2-flop synchronizer. Both flops reset to 1. Call its output `line`; `line_d` is `line` delayed one cycle.
- FSM states: IDLE, START, DATA, STOP, BREAK. Reset state is IDLE.
  - IDLE: on `line_d`=1 && `line`=0 (falling edge), go to START and load the bit counter with HALF_PULSE_WIDTH-1.
  - START: decrement the counter. At 0, sample `line`.
    - If 1: glitch; return to IDLE with no output.
    - If 0: go to DATA, set bit index=0, load PULSE_WIDTH-1.
  - DATA: at counter 0, shift `line` into the shift register at bit[index] (LSB first) and reload PULSE_WIDTH-1. After index DATA_WIDTH-1, go to STOP.
  - STOP: at counter 0, sample `line`.
    - If 1 and valid=0: load data from the shift register, set valid=1, go to IDLE.
    - If 1 and valid=1: pulse overrun; data is unchanged (the new byte is dropped); go to IDLE.
    - If 0: pulse frame_err; the byte is discarded; go to BREAK.
  - BREAK: wait until `line`=1, then go to IDLE. A line held low, or a break condition, never produces bytes.
- valid clears on the cycle after valid && ready. data holds its value after the transfer until the next delivery.
- A delivery in the same cycle as an accepting ready counts as a new delivery. valid stays 1, data updates, and no overrun is raised.
- The counter is at least $clog2(PULSE_WIDTH)+1 bits wide. The bit index is $clog2(DATA_WIDTH) bits wide, or 1 bit if DATA_WIDTH=1.

## Timing
- Reset values: data=0, valid=0, frame_err=0, overrun=0. The FSM returns to IDLE and the synchronizer flops go to 1.
- T0 is the clock edge on which the falling edge is detected in IDLE.
  - Start sample: T0+HALF_PULSE_WIDTH.
  - Data bit i sample: T0+HALF_PULSE_WIDTH+(i+1)·PULSE_WIDTH.
  - Stop sample: T0+HALF_PULSE_WIDTH+(DATA_WIDTH+1)·PULSE_WIDTH.
  - valid, frame_err and overrun take effect on the edge after the stop sample.
- End-to-end latency from a sig transition to detection is 3 cycles: 2 synchronizer flops plus the edge register.
- The FSM re-enters IDLE at mid-stop-bit. A start bit following immediately, with zero idle time, is detected.
- rstn low at any point, including mid-frame, aborts the frame. No output pulse is raised. The block restarts in IDLE and the next falling edge is honoured.
- frame_err and overrun are never asserted in the same cycle.

## Structure
- Shared package `uart_pkg`:
  - rx state enum `rx_state_t` (2-bit is too small; use 3-bit);
  - functions `pulse_width(clk_freq, baud)` and `half_pulse_width(...)`, so TX and RX agree on bit timing.
- One sub-module: `sync_2ff`, a parameterised reset-value 2-flop synchronizer, reusable for other async inputs.
- Everything else stays in a single always_ff FSM plus the output registers.

## Test plan
1. Loopback from the team transmitter at default parameters, ready=1. Send 0xA5 → valid pulses once with data=0xA5. Then send 0x00 and 0xFF → data=0x00, then 0xFF. No error pulses.
2. Glitch: sig low for 20 cycles, then high → no START→DATA transition, valid=0, no error pulses.
3. Framing error: frame 0x3C with the stop bit driven low, line held low for 500 cycles, then high, then a valid 0x81 frame → frame_err pulses once. No valid for 0x3C. The FSM stays in BREAK until the line goes high. data=0x81 is then delivered.
4. Overrun: ready=0. Send 0x12, then 0x34 → valid=1 with data=0x12, overrun pulses once at the 0x34 stop sample. Raising ready clears valid on the next cycle, and data stays 0x12.
5. Back-to-back: send 0x55 and 0xAA with zero idle time, ready=1 → both delivered in order. Check the sample instants against the Timing formulas, within 1 cycle.
6. Reset mid-frame: assert rstn low for 1 cycle at data bit 3 of a frame → all outputs go to their reset values with no output pulse. A following 0x7E frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
//==============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver state encoding and bit-timing
//               helpers so transmitter and receiver derive identical periods.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    function automatic int pulse_width(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int half_pulse_width(input int clk_freq, input int baud);
        return pulse_width(clk_freq, baud) / 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
//==============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous input, with a
//               configurable reset value.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
//==============================================================================
// Module      : uart_rx
// Description : UART receiver with mid-bit sampling, valid/ready byte output
//               and one-cycle framing-error / overrun pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 12_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sig,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int c_PULSE_WIDTH = pulse_width(CLK_FREQ, BAUD_RATE);
    localparam int c_HALF_WIDTH  = half_pulse_width(CLK_FREQ, BAUD_RATE);
    localparam int c_CNT_W       = $clog2(c_PULSE_WIDTH) + 1;
    localparam int c_IDX_W       = (DATA_WIDTH == 1) ? 1 : $clog2(DATA_WIDTH);

    localparam logic [c_CNT_W-1:0] c_PULSE_RELOAD = c_CNT_W'(c_PULSE_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_RELOAD  = c_CNT_W'(c_HALF_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE      = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST     = c_IDX_W'(DATA_WIDTH - 1);

    logic                  w_line;
    logic                  r_line_d;
    rx_state_t             r_state,  w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt,    w_cnt_nxt;
    logic [c_IDX_W-1:0]    r_idx,    w_idx_nxt;
    logic [DATA_WIDTH-1:0] r_shift,  w_shift_nxt;
    logic [DATA_WIDTH-1:0] r_data,   w_data_nxt;
    logic                  r_valid,  w_valid_nxt;
    logic                  r_ferr,   w_ferr_nxt;
    logic                  r_ovr,    w_ovr_nxt;
    logic                  w_cnt_zero;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (sig),
        .q    (w_line)
    );

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_line_d <= 1'b1;
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_line_d <= w_line;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
            r_ferr   <= w_ferr_nxt;
            r_ovr    <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid & ~ready;
        w_ferr_nxt  = 1'b0;
        w_ovr_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_line_d && !w_line) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = c_HALF_RELOAD;
                end
            end
            ST_START: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else if (w_line) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DATA;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = c_PULSE_RELOAD;
                end
            end
            ST_DATA: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else begin
                    w_shift_nxt[r_idx] = w_line;
                    w_cnt_nxt          = c_PULSE_RELOAD;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_ONE;
                    end
                end
            end
            ST_STOP: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else if (w_line) begin
                    // A byte accepted this same cycle frees the slot for the new one
                    if (!r_valid || ready) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_ovr_nxt = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (w_line) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//==============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx at default parameters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int c_PW   = 104;
    localparam int c_HALF = 52;
    // drive-to-delivery: 3 cycles detection + half bit + 9 full bits
    localparam int c_LAT  = 3 + c_HALF + 9 * c_PW;

    typedef struct {
        logic [7:0] byte_in;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk;
    logic       rstn;
    logic       sig;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    int         cyc;
    int         checks;
    int         errors;
    int         n_ferr;
    int         n_ovr;
    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    vec_t       vecs[4];

    uart_rx u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .sig       (sig),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && ready) begin
            rx_q.push_back(data);
            rx_cyc.push_back(cyc);
        end
        if (frame_err) n_ferr = n_ferr + 1;
        if (overrun)   n_ovr  = n_ovr + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output int t_start);
        t_start = cyc;
        sig = 1'b0;
        idle(c_PW);
        for (int i = 0; i < 8; i++) begin
            sig = b[i];
            idle(c_PW);
        end
        sig = stop;
        idle(c_PW);
    endtask

    initial begin
        int base;
        int bf;
        int bo;
        int t1;
        int t2;
        int d;

        checks = 0;
        errors = 0;
        n_ferr = 0;
        n_ovr  = 0;
        rstn   = 1'b0;
        sig    = 1'b1;
        ready  = 1'b1;

        vecs[0] = '{8'hA5, 8'hA5};
        vecs[1] = '{8'h00, 8'h00};
        vecs[2] = '{8'hFF, 8'hFF};
        vecs[3] = '{8'h3C, 8'h3C};

        idle(5);
        check("reset_data",  int'(data), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_ferr",  int'(frame_err), 0);
        check("reset_ovr",   int'(overrun), 0);
        rstn = 1'b1;
        idle(10);

        // Plain deliveries with ready held high
        for (int v = 0; v < 4; v++) begin
            base = rx_q.size();
            send_frame(vecs[v].byte_in, 1'b1, t1);
            idle(20);
            check($sformatf("vec%0d_count", v), rx_q.size(), base + 1);
            if (rx_q.size() == base + 1)
                check($sformatf("vec%0d_data", v), int'(rx_q[base]), int'(vecs[v].exp_data));
            check($sformatf("vec%0d_hold", v), int'(data), int'(vecs[v].exp_data));
            check($sformatf("vec%0d_err", v), n_ferr + n_ovr, 0);
        end

        // Glitch shorter than half a bit
        base = rx_q.size();
        sig = 1'b0;
        idle(20);
        sig = 1'b1;
        idle(200);
        check("glitch_count", rx_q.size(), base);
        check("glitch_valid", int'(valid), 0);
        check("glitch_err", n_ferr + n_ovr, 0);

        // Framing error, then break, then recovery
        base = rx_q.size();
        bf   = n_ferr;
        send_frame(8'h3C, 1'b0, t1);
        idle(500);
        check("ferr_pulse", n_ferr, bf + 1);
        check("ferr_no_byte", rx_q.size(), base);
        sig = 1'b1;
        idle(30);
        send_frame(8'h81, 1'b1, t1);
        idle(20);
        check("ferr_recover_count", rx_q.size(), base + 1);
        check("ferr_recover_data", int'(data), 8'h81);
        check("ferr_total", n_ferr, bf + 1);

        // Overrun with consumer stalled
        ready = 1'b0;
        bo = n_ovr;
        bf = n_ferr;
        send_frame(8'h12, 1'b1, t1);
        send_frame(8'h34, 1'b1, t1);
        idle(20);
        check("ovr_valid", int'(valid), 1);
        check("ovr_data", int'(data), 8'h12);
        check("ovr_pulse", n_ovr, bo + 1);
        check("ovr_no_ferr", n_ferr, bf);
        ready = 1'b1;
        idle(1);
        check("ovr_valid_clear", int'(valid), 0);
        check("ovr_data_hold", int'(data), 8'h12);
        idle(10);

        // Back-to-back frames with no idle time, plus sample-instant timing
        base = rx_q.size();
        send_frame(8'h55, 1'b1, t1);
        send_frame(8'hAA, 1'b1, t2);
        idle(20);
        check("b2b_count", rx_q.size(), base + 2);
        if (rx_q.size() == base + 2) begin
            check("b2b_data0", int'(rx_q[base]), 8'h55);
            check("b2b_data1", int'(rx_q[base + 1]), 8'hAA);
            d = rx_cyc[base] - (t1 + c_LAT);
            check("b2b_time0", int'(d >= -1 && d <= 1), 1);
            d = rx_cyc[base + 1] - (t2 + c_LAT);
            check("b2b_time1", int'(d >= -1 && d <= 1), 1);
        end
        check("b2b_err", n_ferr + n_ovr, bf + bo + 1);

        // Reset pulse in the middle of data bit 3 of 0xF8
        base = rx_q.size();
        bf   = n_ferr;
        bo   = n_ovr;
        sig  = 1'b0;
        idle(c_PW * 4);
        sig  = 1'b1;
        idle(c_HALF);
        rstn = 1'b0;
        idle(1);
        check("rst_data", int'(data), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_pulses", int'(frame_err) + int'(overrun), 0);
        rstn = 1'b1;
        idle(c_HALF + c_PW * 5 + 50);
        check("rst_no_byte", rx_q.size(), base);
        check("rst_no_err", (n_ferr - bf) + (n_ovr - bo), 0);
        send_frame(8'h7E, 1'b1, t1);
        idle(20);
        check("rst_next_count", rx_q.size(), base + 1);
        check("rst_next_data", int'(data), 8'h7E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
